tqvp_spi_bridge: RTL and testbench

TQVP_SPI_BRIDGE -- requirements
Module: tqvp_spi_bridge

---
 rtl/tqvp_spi_bridge.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_tqvp_spi_bridge.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tqvp_spi_bridge.sv
// SPI mode-0 slave that turns framed register accesses into per-channel read/write strobes.
// Optional SPI_BRIDGE_STATUS_EN appends an 8-bit status byte on MISO after each data phase.
module tqvp_spi_bridge #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned NUM_CH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_cs_n,
    input  logic                  spi_clk,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic [ADDR_W-1:0]     address,
    output logic [31:0]           data_in,
    output logic [2*NUM_CH-1:0]   data_write_n,
    output logic [2*NUM_CH-1:0]   data_read_n,
    input  logic [32*NUM_CH-1:0]  data_out,
    input  logic [NUM_CH-1:0]     data_ready,
    output logic                  err,
    input  logic                  err_clr,
    output logic                  busy
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned STB_W  = 2 * NUM_CH;
    localparam logic [2:0]  NUM_CH_L = 3'(NUM_CH);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_WDATA, S_RD_WAIT, S_RDATA, S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic                spi_clk_q, cs_n_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [14:0]         hdr_q, hdr_d;
    logic [1:0]          wid_q, wid_d;
    logic [1:0]          ch_q, ch_d;
    logic                ok_q, ok_d;
    logic [DATA_W-2:0]   wsh_q, wsh_d;
    logic [DATA_W-1:0]   rd_q, rd_d;
    logic                rd_act_q, rd_act_d;
    logic                miso_q, miso_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [DATA_W-1:0]   data_in_q, data_in_d;
    logic [STB_W-1:0]    wr_n_q, wr_n_d;
    logic [STB_W-1:0]    rd_n_q, rd_n_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;

    logic                spi_rise, spi_fall;
    logic [15:0]         hdr_full;
    logic                hdr_ok;
    logic [CNT_W-1:0]    nbits;
    logic                last_bit;
    logic [DATA_W-1:0]   sel_out;
    logic                sel_rdy;
    logic [DATA_W-1:0]   cap_v;
    logic                err_set;
    logic                wr_fire;

    function automatic logic [CNT_W-1:0] width_bits(input logic [1:0] w);
        case (w)
            2'b00:   return 6'd8;
            2'b01:   return 6'd16;
            default: return 6'd32;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] width_mask(input logic [1:0] w);
        case (w)
            2'b00:   return 32'h0000_00FF;
            2'b01:   return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [STB_W-1:0] strobe_vec(input logic [1:0] ch, input logic [1:0] w);
        logic [STB_W-1:0] v;
        v = '1;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ch == 2'(c)) v[2*c +: 2] = w;
        end
        return v;
    endfunction

    assign spi_rise = spi_clk & ~spi_clk_q;
    assign spi_fall = ~spi_clk & spi_clk_q;
    assign hdr_full = {hdr_q, spi_mosi};
    assign hdr_ok   = (hdr_full[14:13] != 2'b11) && ({1'b0, hdr_full[12:11]} < NUM_CH_L);
    assign nbits    = width_bits(wid_q);
    assign last_bit = (cnt_q == nbits - 6'd1);

`ifdef SPI_BRIDGE_STATUS_EN
    logic [7:0] status_v;
    assign status_v = {err_q, 3'b000, ch_q, wid_q};
`endif

    // Read data and handshake of the addressed channel
    always_comb begin
        sel_out = '1;
        sel_rdy = 1'b0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ch_q == 2'(c)) begin
                sel_out = data_out[32*c +: 32];
                sel_rdy = data_ready[c];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hdr_d     = hdr_q;
        wid_d     = wid_q;
        ch_d      = ch_q;
        ok_d      = ok_q;
        wsh_d     = wsh_q;
        rd_d      = rd_q;
        rd_act_d  = rd_act_q;
        miso_d    = 1'b0;
        address_d = address_q;
        data_in_d = data_in_q;
        cap_v     = rd_q;
        err_set   = 1'b0;
        wr_fire   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // cs_n_q resets low so a frame already in flight at reset is not joined
                if (!spi_cs_n && cs_n_q) state_d = S_HDR;
            end
            S_HDR: begin
                if (spi_rise) begin
                    hdr_d = hdr_full[14:0];
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd15) begin
                        cnt_d     = '0;
                        wid_d     = hdr_full[14:13];
                        ch_d      = hdr_full[12:11];
                        ok_d      = hdr_ok;
                        address_d = hdr_full[ADDR_W-1:0];
                        err_set   = !hdr_ok;
                        wsh_d     = '0;
                        if (hdr_full[15]) begin
                            state_d = S_WDATA;
                        end else begin
                            state_d  = S_RD_WAIT;
                            rd_act_d = hdr_ok;
                            rd_d     = '1;
                        end
                    end
                end
            end
            S_WDATA: begin
                if (spi_rise) begin
                    wsh_d = {wsh_q[DATA_W-3:0], spi_mosi};
                    cnt_d = cnt_q + 6'd1;
                    if (last_bit) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                        wr_fire = ok_q;
                        if (ok_q) data_in_d = {wsh_q, spi_mosi};
                    end
                end
            end
            S_RD_WAIT: begin
                if (rd_act_q && sel_rdy) begin
                    cap_v    = sel_out & width_mask(wid_q);
                    rd_act_d = 1'b0;
                end else if (rd_act_q && spi_rise && cnt_q == 6'd7) begin
                    cap_v    = '1;
                    rd_act_d = 1'b0;
                    err_set  = 1'b1;
                end
                rd_d = cap_v;
                if (spi_rise) begin
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd7) begin
                        cnt_d    = '0;
                        state_d  = S_RDATA;
                        rd_act_d = 1'b0;
                        // Left-align so the MSB of the active width shifts out first
                        rd_d     = cap_v << (6'd32 - nbits);
                    end
                end
            end
            S_RDATA: begin
                miso_d = miso_q;
                if (spi_fall) begin
                    miso_d = rd_q[DATA_W-1];
                    rd_d   = {rd_q[DATA_W-2:0], 1'b0};
                end
                if (spi_rise) begin
                    cnt_d = cnt_q + 6'd1;
                    if (last_bit) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                        miso_d  = 1'b0;
                    end
                end
            end
            S_DONE: begin
`ifdef SPI_BRIDGE_STATUS_EN
                if (cnt_q < 6'd8) begin
                    miso_d = miso_q;
                    if (spi_fall) miso_d = status_v[3'd7 - cnt_q[2:0]];
                    if (spi_rise) begin
                        cnt_d = cnt_q + 6'd1;
                        if (cnt_q == 6'd7) miso_d = 1'b0;
                    end
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // Deselect aborts any frame; nothing pending may complete
        if (spi_cs_n) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            rd_act_d  = 1'b0;
            wr_fire   = 1'b0;
            miso_d    = 1'b0;
            data_in_d = data_in_q;
        end
    end

    always_comb begin
        err_d = err_q;
        if (err_clr) err_d = 1'b0;
        if (err_set) err_d = 1'b1;
        wr_n_d = wr_fire ? strobe_vec(ch_q, wid_q) : '1;
        rd_n_d = rd_act_d ? strobe_vec(ch_d, wid_d) : '1;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            spi_clk_q <= 1'b0;
            cs_n_q    <= 1'b0;
            cnt_q     <= '0;
            hdr_q     <= '0;
            wid_q     <= '0;
            ch_q      <= '0;
            ok_q      <= 1'b0;
            wsh_q     <= '0;
            rd_q      <= '0;
            rd_act_q  <= 1'b0;
            miso_q    <= 1'b0;
            address_q <= '0;
            data_in_q <= '0;
            wr_n_q    <= '1;
            rd_n_q    <= '1;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            spi_clk_q <= spi_clk;
            cs_n_q    <= spi_cs_n;
            cnt_q     <= cnt_d;
            hdr_q     <= hdr_d;
            wid_q     <= wid_d;
            ch_q      <= ch_d;
            ok_q      <= ok_d;
            wsh_q     <= wsh_d;
            rd_q      <= rd_d;
            rd_act_q  <= rd_act_d;
            miso_q    <= miso_d;
            address_q <= address_d;
            data_in_q <= data_in_d;
            wr_n_q    <= wr_n_d;
            rd_n_q    <= rd_n_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign spi_miso     = miso_q;
    assign address      = address_q;
    assign data_in      = data_in_q;
    assign data_write_n = wr_n_q;
    assign data_read_n  = rd_n_q;
    assign err          = err_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_tqvp_spi_bridge.sv
// Directed bench for tqvp_spi_bridge: SPI master tasks, strobe monitor and a data_ready responder.
module tb_tqvp_spi_bridge;

    logic        clk;
    logic        rst_n;
    logic        spi_cs_n, spi_clk, spi_mosi, spi_miso;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [3:0]  data_write_n, data_read_n;
    logic [63:0] data_out;
    logic [1:0]  data_ready;
    logic        err, err_clr, busy;

    int          vectors;
    int          miscompares;
    int          wr_cnt, rd_cnt;
    logic [3:0]  wr_vec, rd_vec;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rdy_en;
    logic [1:0]  rdy_mask;
    logic [31:0] rx;

    tqvp_spi_bridge #(.ADDR_W(6), .NUM_CH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .address(address), .data_in(data_in),
        .data_write_n(data_write_n), .data_read_n(data_read_n),
        .data_out(data_out), .data_ready(data_ready),
        .err(err), .err_clr(err_clr), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor; data_ready rises on the third strobed cycle and drops once released
    always @(negedge clk) begin
        if (data_write_n != 4'b1111) begin
            wr_cnt  = wr_cnt + 1;
            wr_vec  = data_write_n;
            wr_addr = address;
            wr_data = data_in;
        end
        if (data_read_n != 4'b1111) begin
            rd_cnt = rd_cnt + 1;
            rd_vec = data_read_n;
            if (rdy_en && rd_cnt == 3) data_ready = rdy_mask;
        end else begin
            data_ready = 2'b00;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer_bit(input logic b, output logic m);
        spi_mosi = b;
        repeat (4) @(negedge clk);
        m = spi_miso;
        spi_clk = 1'b1;
        repeat (4) @(negedge clk);
        spi_clk = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n, output logic [31:0] r);
        logic m;
        r = '0;
        for (int i = n - 1; i >= 0; i--) begin
            xfer_bit(v[i], m);
            r = {r[30:0], m};
        end
    endtask

    task automatic start_frame();
        wr_cnt = 0;
        rd_cnt = 0;
        wr_vec = 4'hx;
        rd_vec = 4'hx;
        spi_cs_n = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic end_frame();
        spi_cs_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        wr_cnt = 0; rd_cnt = 0;
        rst_n = 1'b0; spi_cs_n = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
        err_clr = 1'b0; rdy_en = 1'b0; rdy_mask = 2'b00; data_ready = 2'b00;
        data_out = {32'hDEAD_BEEF, 32'hCAFE_F00D};
        repeat (3) @(negedge clk);

        check("rst_miso", 32'(spi_miso), 32'h0);
        check("rst_addr", 32'(address), 32'h0);
        check("rst_din", data_in, 32'h0);
        check("rst_wr_n", 32'(data_write_n), 32'hF);
        check("rst_rd_n", 32'(data_read_n), 32'hF);
        check("rst_err", 32'(err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 8-bit write ch0, header address field 0x004
        start_frame();
        send_bits(32'h8004, 16, rx);
        check("w8_busy", 32'(busy), 32'h1);
        send_bits(32'hA5, 8, rx);
        end_frame();
        check("w8_cnt", 32'(wr_cnt), 32'd1);
        check("w8_vec", 32'(wr_vec), 32'hC);
        check("w8_addr", 32'(wr_addr), 32'h04);
        check("w8_data", wr_data, 32'h0000_00A5);
        check("w8_hold", data_in, 32'h0000_00A5);
        check("w8_idle", 32'(busy), 32'h0);

        // 16-bit write ch1, address field 0x7C5 truncated to 6 bits
        start_frame();
        send_bits(32'hAFC5, 16, rx);
        send_bits(32'h1234, 16, rx);
        end_frame();
        check("w16_cnt", 32'(wr_cnt), 32'd1);
        check("w16_vec", 32'(wr_vec), 32'h7);
        check("w16_addr", 32'(wr_addr), 32'h05);
        check("w16_data", wr_data, 32'h0000_1234);

        // 32-bit read ch1 with data_ready three cycles into the strobe
        rdy_en = 1'b1; rdy_mask = 2'b10;
        start_frame();
        send_bits(32'h4810, 16, rx);
        send_bits(32'h0, 8, rx);
        check("r32_rdcnt", 32'(rd_cnt), 32'd3);
        check("r32_vec", 32'(rd_vec), 32'hB);
        check("r32_addr", 32'(address), 32'h10);
        send_bits(32'h0, 32, rx);
        check("r32_miso", rx, 32'hDEAD_BEEF);
        end_frame();
        check("r32_err", 32'(err), 32'h0);

        // 8-bit read ch0, upper bits of data_out must not appear
        rdy_mask = 2'b01;
        start_frame();
        send_bits(32'h0002, 16, rx);
        send_bits(32'h0, 8, rx);
        check("r8_vec", 32'(rd_vec), 32'hC);
        send_bits(32'h0, 8, rx);
        check("r8_miso", rx, 32'h0000_000D);
        end_frame();

        // Read timeout: strobe spans exactly the 8 dummy bit periods
        rdy_en = 1'b0;
        start_frame();
        send_bits(32'h4810, 16, rx);
        send_bits(32'h0, 8, rx);
        check("to_rdcnt", 32'(rd_cnt), 32'd64);
        send_bits(32'h0, 32, rx);
        check("to_miso", rx, 32'hFFFF_FFFF);
        end_frame();
        check("to_err", 32'(err), 32'h1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        check("to_errclr", 32'(err), 32'h0);

        // 32-bit write aborted after 20 data bits
        start_frame();
        send_bits(32'hC000, 16, rx);
        send_bits(32'h000F_FFFF, 20, rx);
        check("ab_busy", 32'(busy), 32'h1);
        end_frame();
        check("ab_wrcnt", 32'(wr_cnt), 32'd0);
        check("ab_idle", 32'(busy), 32'h0);
        check("ab_din", data_in, 32'h0000_1234);

        // Channel 3 on a two-channel bridge
        rdy_en = 1'b1; rdy_mask = 2'b11;
        start_frame();
        send_bits(32'h5800, 16, rx);
        check("ch3_err", 32'(err), 32'h1);
        send_bits(32'h0, 8, rx);
        send_bits(32'h0, 32, rx);
        check("ch3_miso", rx, 32'hFFFF_FFFF);
        send_bits(32'h0, 8, rx);
`ifdef SPI_BRIDGE_STATUS_EN
        check("ch3_status", rx, 32'h0000_008E);
`else
        check("ch3_status", rx, 32'h0000_0000);
`endif
        end_frame();
        check("ch3_rdcnt", 32'(rd_cnt), 32'd0);
        check("ch3_wrcnt", 32'(wr_cnt), 32'd0);

        // Reset in the middle of RDATA, cs_n still asserted
        rdy_mask = 2'b10;
        start_frame();
        send_bits(32'h4810, 16, rx);
        send_bits(32'h0, 8, rx);
        send_bits(32'h0, 12, rx);
        rst_n = 1'b0;
        #1;
        check("mr_miso", 32'(spi_miso), 32'h0);
        check("mr_busy", 32'(busy), 32'h0);
        check("mr_rd_n", 32'(data_read_n), 32'hF);
        check("mr_wr_n", 32'(data_write_n), 32'hF);
        check("mr_addr", 32'(address), 32'h0);
        check("mr_din", data_in, 32'h0);
        check("mr_err", 32'(err), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send_bits(32'h8004, 16, rx);
        check("mr_wait", 32'(busy), 32'h0);
        end_frame();

        start_frame();
        send_bits(32'h8004, 16, rx);
        send_bits(32'h3C, 8, rx);
        end_frame();
        check("post_cnt", 32'(wr_cnt), 32'd1);
        check("post_data", wr_data, 32'h0000_003C);
        check("post_addr", 32'(wr_addr), 32'h04);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
